// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   state_e   : arbiter FSM states (IDLE, EXEC, RESP)
//   SEL_* / MODE_* : ALU function encodings used by clients
//   alu_req_t : one ALU operation {mode, select, a, b, carry}
//   alu_rsp_t : one captured ALU result {result, carry, compare}
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] SEL_ADD    = 4'b1001;
  localparam logic [3:0] SEL_XOR    = 4'b0110;
  localparam logic [3:0] SEL_DBL    = 4'b1100;
  localparam logic [3:0] SEL_AND    = 4'b1011;
  localparam logic       MODE_LOGIC = 1'b1;
  localparam logic       MODE_ARITH = 1'b0;

  typedef struct packed {
    logic             mode;
    logic [3:0]       select;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             carry;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             carry;
    logic             compare;
  } alu_rsp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   req[1:0]  : request vector (bit n = requester n)
//   done      : pulse when the granted operation completes
//   done_id   : id of the requester whose operation completed
//   grant     : one-hot (or zero) combinational grant
//   grant_id  : index of the granted requester (0 when nothing is granted)
// The pointer only matters when both request; after a completion it moves
// to the requester that was not served.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (done) begin
      ptr <= ~done_id;
    end
  end

  // Requester 1 wins when it is the only one asking, or when both ask and
  // the pointer favours it.
  always_comb begin
    grant_id = req[1] & (~req[0] | ptr);
    grant    = {req[1] & grant_id, req[0] & ~grant_id};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 16-bit ALU between two requesters.
//   clk, reset         : clock, asynchronous active-high reset
//   rN_req_*           : request from requester N (valid/ready + operands)
//   rN_rsp_*           : response to requester N (valid/ready + result)
//   alu_*  (outputs)   : registered operands driving the external ALU
//   alu_result/carry_out/compare (inputs) : ALU outputs, sampled after
//                        ALU_LATENCY cycles of stable operands
//   busy               : high whenever the FSM is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. req_ready is combinational and only asserts in IDLE for
// the arbitration winner; rsp_valid stays high with stable data until
// rsp_ready, and only the granted port's rsp_valid ever asserts.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_mode,
  input  logic [3:0]        r0_req_select,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic              r0_req_carry,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_result,
  output logic              r0_rsp_carry,
  output logic              r0_rsp_compare,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_mode,
  input  logic [3:0]        r1_req_select,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  input  logic              r1_req_carry,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_result,
  output logic              r1_rsp_carry,
  output logic              r1_rsp_compare,
  output logic              alu_mode,
  output logic [3:0]        alu_select,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_compare,
  output logic              busy
);

  localparam logic [3:0] LAST_CNT = 4'(ALU_LATENCY - 1);

  state_e   state, state_nx;
  alu_req_t drv_q;
  alu_rsp_t rsp_q;
  logic     gnt_id_q;
  logic [3:0] cnt_q;

  alu_req_t r0_req, r1_req;
  logic [1:0] grant;
  logic       grant_id;
  logic       rsp_hs;
  logic       exec_last;

  assign r0_req = {r0_req_mode, r0_req_select, r0_req_a, r0_req_b, r0_req_carry};
  assign r1_req = {r1_req_mode, r1_req_select, r1_req_a, r1_req_b, r1_req_carry};

  assign exec_last = (cnt_q == LAST_CNT);
  assign rsp_hs    = (state == RESP) & (gnt_id_q ? r1_rsp_ready : r0_rsp_ready);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({r1_req_valid, r0_req_valid}),
    .done     (rsp_hs),
    .done_id  (gnt_id_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|grant) state_nx = EXEC;
      EXEC:    if (exec_last) state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drive registers are loaded only on a grant and otherwise hold their
  // last value, so the ALU inputs do not toggle between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      drv_q    <= '0;
      rsp_q    <= '0;
      gnt_id_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|grant) begin
            drv_q    <= grant_id ? r1_req : r0_req;
            gnt_id_q <= grant_id;
            cnt_q    <= '0;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 4'd1;
          if (exec_last) begin
            rsp_q.result  <= alu_result;
            // Carry is undefined for logic operations; report it as 0.
            rsp_q.carry   <= alu_carry_out & ~drv_q.mode;
            rsp_q.compare <= alu_compare;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign r0_req_ready = (state == IDLE) & ~reset & grant[0];
  assign r1_req_ready = (state == IDLE) & ~reset & grant[1];

  assign r0_rsp_valid = (state == RESP) & ~gnt_id_q;
  assign r1_rsp_valid = (state == RESP) &  gnt_id_q;

  assign r0_rsp_result  = rsp_q.result;
  assign r0_rsp_carry   = rsp_q.carry;
  assign r0_rsp_compare = rsp_q.compare;
  assign r1_rsp_result  = rsp_q.result;
  assign r1_rsp_carry   = rsp_q.carry;
  assign r1_rsp_compare = rsp_q.compare;

  assign alu_mode     = drv_q.mode;
  assign alu_select   = drv_q.select;
  assign alu_in_a     = drv_q.a;
  assign alu_in_b     = drv_q.b;
  assign alu_carry_in = drv_q.carry;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: dut1 uses ALU_LATENCY=1, dut3 ALU_LATENCY=3.
// Each instance drives a small behavioural ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int EXP_W = 19;  // {port id, result[15:0], carry, compare}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut1 signals ----------------
  logic        r0_req_valid, r0_req_ready, r0_req_mode, r0_req_carry;
  logic [3:0]  r0_req_select;
  logic [15:0] r0_req_a, r0_req_b, r0_rsp_result;
  logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_carry, r0_rsp_compare;
  logic        r1_req_valid, r1_req_ready, r1_req_mode, r1_req_carry;
  logic [3:0]  r1_req_select;
  logic [15:0] r1_req_a, r1_req_b, r1_rsp_result;
  logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_carry, r1_rsp_compare;
  logic        alu_mode, alu_carry_in, alu_carry_out, alu_compare, busy;
  logic [3:0]  alu_select;
  logic [15:0] alu_in_a, alu_in_b, alu_result;
  logic        alu_carry_raw;
  logic        force_c;

  // ---------------- dut3 signals ----------------
  logic        q_r0_req_valid, q_r0_req_ready, q_r0_req_mode, q_r0_req_carry;
  logic [3:0]  q_r0_req_select;
  logic [15:0] q_r0_req_a, q_r0_req_b, q_r0_rsp_result;
  logic        q_r0_rsp_valid, q_r0_rsp_ready, q_r0_rsp_carry, q_r0_rsp_compare;
  logic        q_r1_req_ready, q_r1_rsp_valid, q_r1_rsp_carry, q_r1_rsp_compare;
  logic [15:0] q_r1_rsp_result;
  logic        q_alu_mode, q_alu_carry_in, q_alu_carry_out, q_alu_compare, q_busy;
  logic [3:0]  q_alu_select;
  logic [15:0] q_alu_in_a, q_alu_in_b, q_alu_result;

  // ---------------- ALU model (returns {result, carry, compare}) ----------------
  function automatic logic [17:0] alu_model(input logic m, input logic [3:0] s,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
    logic [16:0] sum;
    logic [15:0] r;
    sum = '0;
    r   = '0;
    if (m) begin
      case (s)
        4'b0110: r = a ^ b;
        4'b1011: r = a & b;
        4'b1110: r = a | b;
        default: r = ~a;
      endcase
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b} + {16'd0, c};
        4'b1100: sum = {1'b0, a} + {1'b0, a} + {16'd0, c};
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {16'd0, c};
        default: sum = {1'b0, a} + {16'd0, c};
      endcase
      r = sum[15:0];
    end
    return {r, sum[16], (a == b)};
  endfunction

  assign {alu_result, alu_carry_raw, alu_compare} =
    alu_model(alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in);
  assign alu_carry_out = alu_carry_raw | force_c;
  assign {q_alu_result, q_alu_carry_out, q_alu_compare} =
    alu_model(q_alu_mode, q_alu_select, q_alu_in_a, q_alu_in_b, q_alu_carry_in);

  // ---------------- DUTs ----------------
  alu_arbiter #(.ALU_LATENCY(1), .DATA_W(16)) dut1 (
    .clk(clk), .reset(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_mode(r0_req_mode),
    .r0_req_select(r0_req_select), .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
    .r0_req_carry(r0_req_carry), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_result(r0_rsp_result), .r0_rsp_carry(r0_rsp_carry), .r0_rsp_compare(r0_rsp_compare),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_mode(r1_req_mode),
    .r1_req_select(r1_req_select), .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
    .r1_req_carry(r1_req_carry), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_result(r1_rsp_result), .r1_rsp_carry(r1_rsp_carry), .r1_rsp_compare(r1_rsp_compare),
    .alu_mode(alu_mode), .alu_select(alu_select), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_compare(alu_compare), .busy(busy)
  );

  alu_arbiter #(.ALU_LATENCY(3), .DATA_W(16)) dut3 (
    .clk(clk), .reset(rst),
    .r0_req_valid(q_r0_req_valid), .r0_req_ready(q_r0_req_ready), .r0_req_mode(q_r0_req_mode),
    .r0_req_select(q_r0_req_select), .r0_req_a(q_r0_req_a), .r0_req_b(q_r0_req_b),
    .r0_req_carry(q_r0_req_carry), .r0_rsp_valid(q_r0_rsp_valid), .r0_rsp_ready(q_r0_rsp_ready),
    .r0_rsp_result(q_r0_rsp_result), .r0_rsp_carry(q_r0_rsp_carry),
    .r0_rsp_compare(q_r0_rsp_compare),
    .r1_req_valid(1'b0), .r1_req_ready(q_r1_req_ready), .r1_req_mode(1'b0),
    .r1_req_select(4'd0), .r1_req_a(16'd0), .r1_req_b(16'd0),
    .r1_req_carry(1'b0), .r1_rsp_valid(q_r1_rsp_valid), .r1_rsp_ready(1'b0),
    .r1_rsp_result(q_r1_rsp_result), .r1_rsp_carry(q_r1_rsp_carry),
    .r1_rsp_compare(q_r1_rsp_compare),
    .alu_mode(q_alu_mode), .alu_select(q_alu_select), .alu_in_a(q_alu_in_a),
    .alu_in_b(q_alu_in_b), .alu_carry_in(q_alu_carry_in), .alu_result(q_alu_result),
    .alu_carry_out(q_alu_carry_out), .alu_compare(q_alu_compare), .busy(q_busy)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic             gnt_log[$];
  int               n_chk;
  int               n_err;
  logic             acc0, acc1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] exp_calc(input logic id, input logic m,
                                                input logic [3:0] s, input logic [15:0] a,
                                                input logic [15:0] b, input logic c);
    logic [17:0] md;
    md = alu_model(m, s, a, b, c);
    return {id, md[17:2], (m ? 1'b0 : (md[1] | force_c)), md[0]};
  endfunction

  function automatic logic [78:0] outs1();
    return {r0_req_ready, r0_rsp_valid, r0_rsp_result, r0_rsp_carry, r0_rsp_compare,
            r1_req_ready, r1_rsp_valid, r1_rsp_result, r1_rsp_carry, r1_rsp_compare,
            alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in, busy};
  endfunction

  function automatic logic [78:0] outs3();
    return {q_r0_req_ready, q_r0_rsp_valid, q_r0_rsp_result, q_r0_rsp_carry, q_r0_rsp_compare,
            q_r1_req_ready, q_r1_rsp_valid, q_r1_rsp_result, q_r1_rsp_carry, q_r1_rsp_compare,
            q_alu_mode, q_alu_select, q_alu_in_a, q_alu_in_b, q_alu_carry_in, q_busy};
  endfunction

  // Looks at dut1 just before the coming rising edge: accepted requests go
  // into exp_q, completed responses are popped and compared.
  task automatic observe();
    logic [EXP_W-1:0] e;
    logic hs;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (r0_req_valid && r0_req_ready) begin
      exp_q.push_back(exp_calc(1'b0, r0_req_mode, r0_req_select, r0_req_a, r0_req_b, r0_req_carry));
      gnt_log.push_back(1'b0);
      acc0 = 1'b1;
    end
    if (r1_req_valid && r1_req_ready) begin
      exp_q.push_back(exp_calc(1'b1, r1_req_mode, r1_req_select, r1_req_a, r1_req_b, r1_req_carry));
      gnt_log.push_back(1'b1);
      acc1 = 1'b1;
    end
    if (r0_rsp_valid || r1_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {r1_rsp_valid, r0_rsp_valid}, 0);
      end else begin
        e = exp_q[0];
        chk("rsp_port", {r1_rsp_valid, r0_rsp_valid}, e[18] ? 2'b10 : 2'b01);
        hs = (r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready);
        if (hs) begin
          void'(exp_q.pop_front());
          if (e[18]) chk("rsp_data", {r1_rsp_result, r1_rsp_carry, r1_rsp_compare}, e[17:0]);
          else       chk("rsp_data", {r0_rsp_result, r0_rsp_carry, r0_rsp_compare}, e[17:0]);
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the
  // next falling edge.
  task automatic cyc();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- driver tasks ----------------
  logic [3:0] sel_tab[4];
  initial sel_tab = '{SEL_ADD, SEL_XOR, SEL_DBL, SEL_AND};

  task automatic rand_r0();
    r0_req_mode   = 1'($urandom_range(0, 1));
    r0_req_select = sel_tab[$urandom_range(0, 3)];
    r0_req_a      = 16'($urandom);
    r0_req_b      = ($urandom_range(0, 3) == 0) ? r0_req_a : 16'($urandom);
    r0_req_carry  = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_r1();
    r1_req_mode   = 1'($urandom_range(0, 1));
    r1_req_select = sel_tab[$urandom_range(0, 3)];
    r1_req_a      = 16'($urandom);
    r1_req_b      = ($urandom_range(0, 3) == 0) ? r1_req_a : 16'($urandom);
    r1_req_carry  = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  int c0, c1, low_run, wait_n;
  logic [17:0] hold_exp;

  initial begin
    n_chk = 0; n_err = 0; force_c = 1'b0; rst = 1'b1;
    r0_req_valid = 0; r0_req_mode = 0; r0_req_select = 0; r0_req_a = 0; r0_req_b = 0;
    r0_req_carry = 0; r0_rsp_ready = 0;
    r1_req_valid = 0; r1_req_mode = 0; r1_req_select = 0; r1_req_a = 0; r1_req_b = 0;
    r1_req_carry = 0; r1_rsp_ready = 0;
    q_r0_req_valid = 0; q_r0_req_mode = 0; q_r0_req_select = 0; q_r0_req_a = 0;
    q_r0_req_b = 0; q_r0_req_carry = 0; q_r0_rsp_ready = 0;

    #2;
    chk("reset_outs_dut1", outs1(), 0);
    chk("reset_outs_dut3", outs3(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: r0 add FFFF+0001 -> 0000 carry 1, valid at cycle 2
    r0_req_mode = MODE_ARITH; r0_req_select = SEL_ADD; r0_req_a = 16'hFFFF;
    r0_req_b = 16'h0001; r0_req_carry = 1'b0; r0_req_valid = 1'b1; r0_rsp_ready = 1'b1;
    #1 chk("t1_ready_c0", r0_req_ready, 1);
    cyc();
    r0_req_valid = 1'b0;
    #1 chk("t1_valid_c1", r0_rsp_valid, 0);
    chk("t1_busy_c1", busy, 1);
    cyc();
    #1 chk("t1_valid_c2", r0_rsp_valid, 1);
    chk("t1_result", r0_rsp_result, 16'h0000);
    chk("t1_carry", r0_rsp_carry, 1);
    cyc();
    chk("t1_valid_drop", r0_rsp_valid, 0);

    // T2: r1 logic XOR with ALU carry forced high
    force_c = 1'b1;
    r1_req_mode = MODE_LOGIC; r1_req_select = SEL_XOR; r1_req_a = 16'h00FF;
    r1_req_b = 16'h0F0F; r1_req_carry = 1'b0; r1_req_valid = 1'b1; r1_rsp_ready = 1'b1;
    #1 chk("t2_ready_c0", r1_req_ready, 1);
    cyc();
    r1_req_valid = 1'b0;
    #1 chk("t2_r0_rsp_valid", r0_rsp_valid, 0);
    cyc();
    #1 chk("t2_r1_valid", r1_rsp_valid, 1);
    chk("t2_r0_rsp_valid", r0_rsp_valid, 0);
    chk("t2_result", r1_rsp_result, 16'h0FF0);
    chk("t2_carry", r1_rsp_carry, 0);
    cyc();
    chk("t2_r0_rsp_valid", r0_rsp_valid, 0);
    force_c = 1'b0;

    // T3: both valid continuously, two ops each
    gnt_log.delete();
    rand_r0(); rand_r1();
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    c0 = 0; c1 = 0; low_run = 0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || r0_req_valid || r1_req_valid); i++) begin
      cyc();
      if (acc0) begin c0++; rand_r0(); if (c0 == 2) r0_req_valid = 1'b0; end
      if (acc1) begin c1++; rand_r1(); if (c1 == 2) r1_req_valid = 1'b0; end
      if (!busy) low_run++;
      else begin
        if (low_run > 0) chk("t3_busy_gap", low_run, 1);
        low_run = 0;
      end
    end
    chk("t3_drain", {r0_req_valid, r1_req_valid, exp_q.size() != 0}, 0);
    chk("t3_n_grants", gnt_log.size(), 4);
    for (int k = 0; k < gnt_log.size(); k++) chk("t3_grant_order", gnt_log[k], k % 2);

    // T4: r0 response stalled 5 cycles while r1 waits
    rand_r0(); rand_r1();
    r0_req_valid = 1'b1; r1_req_valid = 1'b1; r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b1;
    #1 chk("t4_r0_ready_c0", r0_req_ready, 1);
    chk("t4_r1_ready_c0", r1_req_ready, 0);
    cyc();
    r0_req_valid = 1'b0;
    wait_n = 0;
    while (!r0_rsp_valid && wait_n < 10) begin cyc(); wait_n++; end
    chk("t4_rsp_wait", r0_rsp_valid, 1);
    hold_exp = (exp_q.size() != 0) ? exp_q[0][17:0] : 18'h3FFFF;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_hold_valid", r0_rsp_valid, 1);
      chk("t4_hold_data", {r0_rsp_result, r0_rsp_carry, r0_rsp_compare}, hold_exp);
      chk("t4_r1_ready_hold", r1_req_ready, 0);
      cyc();
    end
    r0_rsp_ready = 1'b1;
    cyc();
    #1 chk("t4_r1_granted", r1_req_ready, 1);
    cyc();
    r1_req_valid = 1'b0;
    drain();

    // T5: ALU_LATENCY=3, r0 A+A+1 with A=8001
    q_r0_req_mode = MODE_ARITH; q_r0_req_select = SEL_DBL; q_r0_req_a = 16'h8001;
    q_r0_req_b = 16'h0000; q_r0_req_carry = 1'b1; q_r0_req_valid = 1'b1; q_r0_rsp_ready = 1'b0;
    #1 chk("t5_ready_c0", q_r0_req_ready, 1);
    cyc();
    q_r0_req_valid = 1'b0; q_r0_req_a = 16'h1234; q_r0_req_select = SEL_XOR;
    for (int c = 1; c <= 3; c++) begin
      #1 chk("t5_valid_early", q_r0_rsp_valid, 0);
      chk("t5_alu_hold", {q_alu_mode, q_alu_select, q_alu_in_a, q_alu_in_b, q_alu_carry_in},
          {1'b0, 4'b1100, 16'h8001, 16'h0000, 1'b1});
      cyc();
    end
    #1 chk("t5_valid_c4", q_r0_rsp_valid, 1);
    chk("t5_result", q_r0_rsp_result, 16'h0003);
    chk("t5_carry", q_r0_rsp_carry, 1);
    q_r0_rsp_ready = 1'b1;
    cyc();
    chk("t5_valid_drop", q_r0_rsp_valid, 0);
    chk("t5_alu_keep", q_alu_in_a, 16'h8001);

    // T6: pointer to r1, then reset mid-EXEC
    rand_r0(); r0_req_valid = 1'b1; r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    cyc();
    r0_req_valid = 1'b0;
    drain();
    rand_r0(); r0_req_valid = 1'b1;
    cyc();
    r0_req_valid = 1'b0; r1_req_valid = 1'b1;
    chk("t6_in_exec", busy, 1);
    #2 rst = 1'b1;
    #1 chk("t6_async_outs1", outs1(), 0);
    chk("t6_async_outs3", outs3(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; r1_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_no_rsp", {r0_rsp_valid, r1_rsp_valid, busy}, 0);
      cyc();
    end
    rand_r0(); rand_r1();
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    #1 chk("t6_r0_wins", {r1_req_ready, r0_req_ready}, 2'b01);
    cyc();
    r0_req_valid = 1'b0;
    for (int i = 0; i < 10 && !acc1; i++) cyc();
    r1_req_valid = 1'b0;
    drain();

    chk("end_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
